// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants for the ALU issue stage
// Ports: none (package). ALU select codes, default widths, zero-register address.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_REG_AW = 5;
    localparam int ALU_SEL_W  = 2;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 2'd0;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 2'd1;
    localparam logic [ALU_SEL_W-1:0] ALU_MUL  = 2'd2;
    localparam logic [ALU_SEL_W-1:0] ALU_NAND = 2'd3;

    localparam logic [ALU_REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/alu_issue_slot.sv
// rtl/alu_issue_slot.sv - one held op entry with load and writeback refresh
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load                capture load_* into the entry (marks valid)
//   drain               empty the entry (ignored when load is set)
//   load_*              op fields to capture (operand data before forwarding)
//   wb_valid/addr/data  writeback bus used for capture forwarding and refresh
//   valid, sel, ...     current entry contents
module alu_issue_slot
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int REG_AW = ALU_REG_AW,
    parameter int SEL_W  = ALU_SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              drain,
    input  logic [SEL_W-1:0]  load_sel,
    input  logic [REG_AW-1:0] load_rs_addr,
    input  logic [REG_AW-1:0] load_rt_addr,
    input  logic [DATA_W-1:0] load_rs_data,
    input  logic [DATA_W-1:0] load_rt_data,
    input  logic [REG_AW-1:0] load_rd_addr,
    input  logic              load_wr_en,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              valid,
    output logic [SEL_W-1:0]  sel,
    output logic [REG_AW-1:0] rs_addr,
    output logic [REG_AW-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [REG_AW-1:0] rd_addr,
    output logic              wr_en
);

    // Same rule serves capture and refresh: register 0 reads as zero, a
    // matching writeback wins, otherwise keep the supplied value.
    function automatic logic [DATA_W-1:0] patch(input logic [REG_AW-1:0] addr,
                                                 input logic [DATA_W-1:0] data);
        if (addr == '0)
            return '0;
        else if (wb_valid && (wb_addr == addr))
            return wb_data;
        else
            return data;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            sel     <= '0;
            rs_addr <= '0;
            rt_addr <= '0;
            rs_data <= '0;
            rt_data <= '0;
            rd_addr <= '0;
            wr_en   <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            sel     <= load_sel;
            rs_addr <= load_rs_addr;
            rt_addr <= load_rt_addr;
            rs_data <= patch(load_rs_addr, load_rs_data);
            rt_data <= patch(load_rt_addr, load_rt_data);
            rd_addr <= load_rd_addr;
            wr_en   <= load_wr_en;
        end else if (drain) begin
            valid   <= 1'b0;
        end else if (valid) begin
            rs_data <= patch(rs_addr, rs_data);
            rt_data <= patch(rt_addr, rt_data);
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - registered operand-forwarding issue stage ahead of the ALU
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         upstream handshake (in_ready is registered)
//   in_sel, in_rs/rt_addr,    decoded op and register-file operands
//   in_rs/rt_data, in_rd_addr, in_wr_en
//   wb_valid/addr/data        writeback bus for forwarding and refresh
//   out_valid/out_ready       ALU-side handshake
//   out_sel, data_1, data_2,  registered op presented to the ALU
//   out_rd_addr, out_wr_en
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int REG_AW = ALU_REG_AW,
    parameter int SEL_W  = ALU_SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [REG_AW-1:0] in_rs_addr,
    input  logic [REG_AW-1:0] in_rt_addr,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic              in_wr_en,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  out_sel,
    output logic [DATA_W-1:0] data_1,
    output logic [DATA_W-1:0] data_2,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_wr_en
);

    logic              in_ready_q;
    logic              in_xfer, out_xfer, promote;
    logic              main_load, main_drain, skid_load, skid_next;
    logic              main_valid, skid_valid;
    logic [REG_AW-1:0] main_rs_addr, main_rt_addr;
    logic [SEL_W-1:0]  skid_sel;
    logic [REG_AW-1:0] skid_rs_addr, skid_rt_addr, skid_rd_addr;
    logic [DATA_W-1:0] skid_rs_data, skid_rt_data;
    logic              skid_wr_en;
    logic [SEL_W-1:0]  m_sel;
    logic [REG_AW-1:0] m_rs_addr, m_rt_addr, m_rd_addr;
    logic [DATA_W-1:0] m_rs_data, m_rt_data;
    logic              m_wr_en;

    assign in_ready = in_ready_q;
    assign out_valid = main_valid;
    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = main_valid & out_ready;

    // Skid can only be occupied while main is, and in_ready is low then, so
    // a promotion never coincides with an input transfer.
    assign promote    = out_xfer & skid_valid;
    assign main_load  = promote | (in_xfer & (~main_valid | out_xfer));
    assign main_drain = out_xfer & ~main_load;
    assign skid_load  = in_xfer & main_valid & ~out_xfer;
    assign skid_next  = skid_load | (skid_valid & ~out_xfer);

    always_ff @(posedge clk) begin
        if (rst)
            in_ready_q <= 1'b1;
        else
            in_ready_q <= ~skid_next;
    end

    // Promoted skid data passes through the main slot's capture forwarding,
    // so a writeback in the promotion cycle is not lost.
    always_comb begin
        m_sel     = in_sel;
        m_rs_addr = in_rs_addr;
        m_rt_addr = in_rt_addr;
        m_rs_data = in_rs_data;
        m_rt_data = in_rt_data;
        m_rd_addr = in_rd_addr;
        m_wr_en   = in_wr_en;
        if (promote) begin
            m_sel     = skid_sel;
            m_rs_addr = skid_rs_addr;
            m_rt_addr = skid_rt_addr;
            m_rs_data = skid_rs_data;
            m_rt_data = skid_rt_data;
            m_rd_addr = skid_rd_addr;
            m_wr_en   = skid_wr_en;
        end
    end

    alu_issue_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW), .SEL_W(SEL_W)) u_main (
        .clk          (clk),
        .rst          (rst),
        .load         (main_load),
        .drain        (main_drain),
        .load_sel     (m_sel),
        .load_rs_addr (m_rs_addr),
        .load_rt_addr (m_rt_addr),
        .load_rs_data (m_rs_data),
        .load_rt_data (m_rt_data),
        .load_rd_addr (m_rd_addr),
        .load_wr_en   (m_wr_en),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .valid        (main_valid),
        .sel          (out_sel),
        .rs_addr      (main_rs_addr),
        .rt_addr      (main_rt_addr),
        .rs_data      (data_1),
        .rt_data      (data_2),
        .rd_addr      (out_rd_addr),
        .wr_en        (out_wr_en)
    );

    alu_issue_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW), .SEL_W(SEL_W)) u_skid (
        .clk          (clk),
        .rst          (rst),
        .load         (skid_load),
        .drain        (promote),
        .load_sel     (in_sel),
        .load_rs_addr (in_rs_addr),
        .load_rt_addr (in_rt_addr),
        .load_rs_data (in_rs_data),
        .load_rt_data (in_rt_data),
        .load_rd_addr (in_rd_addr),
        .load_wr_en   (in_wr_en),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .valid        (skid_valid),
        .sel          (skid_sel),
        .rs_addr      (skid_rs_addr),
        .rt_addr      (skid_rt_addr),
        .rs_data      (skid_rs_data),
        .rt_data      (skid_rt_data),
        .rd_addr      (skid_rd_addr),
        .wr_en        (skid_wr_en)
    );

    // Main-slot addresses are only needed inside the slot for refresh.
    logic unused_main_addr;
    assign unused_main_addr = ^{main_rs_addr, main_rt_addr};

endmodule
